// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: FSM state encoding, data width, default baud divisor and parity helper.
// The ST_PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_fifo_pkg;

   localparam int DATA_W       = 8;
   localparam int BAUD_DIV_DEF = 174;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
      ,
      ST_PARITY = 3'd4
`endif
   } uart_state_t;

   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte write port of the UART transmitter: valid/ready handshake, bridge side is the master.
interface uart_tx_fifo_if;
   import uart_tx_fifo_pkg::*;

   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (output tx_data, output tx_valid, input  tx_ready);
   modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// uart_sync_fifo: synchronous circular FIFO with occupancy count, shared by the UART TX and RX paths.
// Push while full and pop while empty are ignored; the head word is readable combinationally.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk_in,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_INC = AW'(1);
   localparam logic [AW:0]   CNT_INC = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_MAX);
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // storage array, deliberately not reset
   always_ff @(posedge clk_in) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_INC;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_INC;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_INC;
            2'b01:   r_count <= r_count - CNT_INC;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with byte FIFO: 8N1 frames LSB first on uart_txd, idle high.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int BAUD_DIV   = BAUD_DIV_DEF,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk_in,
   input  logic                          sys_rstn,
   uart_tx_fifo_if.slave                 wr,
   output logic                          uart_txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BAUD_INC  = BW'(1);
   localparam logic [2:0]    BIT_LAST  = 3'(DATA_W - 1);

   uart_state_t       r_state;
   uart_state_t       w_state_nxt;
   logic [BW-1:0]     r_baud_cnt;
   logic [BW-1:0]     w_baud_nxt;
   logic [2:0]        r_bit_idx;
   logic [2:0]        w_bit_nxt;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] w_shift_nxt;
   logic              r_txd;
   logic              w_txd_nxt;
   logic              w_baud_done;
   logic              w_pop;
   logic              w_empty;
   logic              w_full;
   logic [DATA_W-1:0] w_fifo_data;

   uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_in  (clk_in),
      .rst_n   (sys_rstn),
      .i_push  (wr.tx_valid),
      .i_data  (wr.tx_data),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );

   assign w_baud_done = (r_baud_cnt == BAUD_LAST);
   assign wr.tx_ready = ~w_full;
   assign busy        = (r_state != ST_IDLE) | ~w_empty;
   assign uart_txd    = r_txd;

   // next state, FIFO pop and shift-register load
   always_comb begin
      w_state_nxt = r_state;
      w_bit_nxt   = r_bit_idx;
      w_shift_nxt = r_shift;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_fifo_data;
               w_state_nxt = ST_START;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_START: begin
            if (w_baud_done) begin
               w_state_nxt = ST_DATA;
               w_bit_nxt   = 3'd0;
            end else begin
               w_state_nxt = ST_START;
            end
         end
         ST_DATA: begin
            if (w_baud_done && (r_bit_idx == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
               w_state_nxt = ST_PARITY;
`else
               w_state_nxt = ST_STOP;
`endif
            end else if (w_baud_done) begin
               w_bit_nxt = r_bit_idx + 3'd1;
            end else begin
               w_state_nxt = ST_DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (w_baud_done) begin
               w_state_nxt = ST_STOP;
            end else begin
               w_state_nxt = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            // a queued byte follows the stop bit with no idle gap
            if (w_baud_done && !w_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_fifo_data;
               w_state_nxt = ST_START;
            end else if (w_baud_done) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_STOP;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // baud counter and registered line value for the upcoming cycle
   always_comb begin
      w_baud_nxt = '0;
      w_txd_nxt  = 1'b1;
      if ((r_state == ST_IDLE) || w_baud_done) begin
         w_baud_nxt = '0;
      end else begin
         w_baud_nxt = r_baud_cnt + BAUD_INC;
      end
      case (w_state_nxt)
         ST_START:  w_txd_nxt = 1'b0;
         ST_DATA:   w_txd_nxt = w_shift_nxt[w_bit_nxt];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: w_txd_nxt = even_parity(w_shift_nxt);
`endif
         default:   w_txd_nxt = 1'b1;
      endcase
   end

   // FSM, datapath and line registers
   always_ff @(posedge clk_in or negedge sys_rstn) begin
      if (!sys_rstn) begin
         r_state    <= ST_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= 3'd0;
         r_shift    <= '0;
         r_txd      <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_baud_cnt <= w_baud_nxt;
         r_bit_idx  <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
         r_txd      <= w_txd_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: frame-level line model plus an independent serial receiver.
module tb_uart_tx_fifo;

   localparam int BAUD  = 4;
   localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME = FRAME_BITS * BAUD;

   logic       clk;
   logic       rst_n;
   logic       uart_txd;
   logic       busy;
   logic [3:0] fifo_count;

   uart_tx_fifo_if wr_if ();

   uart_tx_fifo #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
      .clk_in     (clk),
      .sys_rstn   (rst_n),
      .wr         (wr_if),
      .uart_txd   (uart_txd),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: queue of accepted bytes and position inside the frame on the line
   logic [7:0] m_q[$];
   logic [7:0] exp_rx[$];
   logic       m_active = 1'b0;
   int         m_pos    = 0;
   logic [7:0] m_byte   = 8'h00;
   logic       m_acc    = 1'b0;
   logic       seen_ee  = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic exp_txd();
      int k;
      if (!m_active) return 1'b1;
      k = m_pos / BAUD;
      if (k == 0) return 1'b0;
      if (k <= 8) return m_byte[k-1];
      if ((FRAME_BITS == 11) && (k == 9)) return ^m_byte;
      return 1'b1;
   endfunction

   task automatic model_clear();
      m_q.delete();
      exp_rx.delete();
      m_active = 1'b0;
      m_pos    = 0;
   endtask

   task automatic model_edge(input logic v, input logic [7:0] d);
      m_acc = 1'b0;
      if (!rst_n) begin
         model_clear();
      end else begin
         m_acc = v && (m_q.size() < DEPTH);
         if ((!m_active || (m_pos == FRAME - 1)) && (m_q.size() > 0)) begin
            m_byte   = m_q.pop_front();
            m_pos    = 0;
            m_active = 1'b1;
            exp_rx.push_back(m_byte);
         end else if (m_active) begin
            if (m_pos == FRAME - 1) m_active = 1'b0;
            else m_pos++;
         end
         if (m_acc) m_q.push_back(d);
      end
   endtask

   task automatic compare_all();
      check_val("txd",   32'(uart_txd),         32'(exp_txd()));
      check_val("count", 32'(fifo_count),       32'(m_q.size()));
      check_val("ready", 32'(wr_if.tx_ready),   32'(m_q.size() < DEPTH));
      check_val("busy",  32'(busy),             32'(m_active || (m_q.size() > 0)));
   endtask

   task automatic cycle(input logic v, input logic [7:0] d);
      wr_if.tx_valid = v;
      wr_if.tx_data  = d;
      @(posedge clk);
      model_edge(v, d);
      #1;
      compare_all();
   endtask

   task automatic drain();
      int guard = 0;
      while ((m_active || (m_q.size() > 0)) && (guard < 2000)) begin
         cycle(1'b0, 8'h00);
         guard++;
      end
      check_val("drain_timeout", 32'(guard < 2000), 32'd1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00);
   endtask

   // independent receiver: mid-bit sampling after a detected start bit
   initial begin
      logic       rx_on = 1'b0;
      int         rx_cnt = 0;
      int         k;
      logic [7:0] rx_b = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rx_on = 1'b0;
         end else if (!rx_on) begin
            if (uart_txd == 1'b0) begin
               rx_on  = 1'b1;
               rx_cnt = 0;
            end
         end else begin
            rx_cnt++;
            if ((rx_cnt % BAUD) == (BAUD / 2)) begin
               k = rx_cnt / BAUD;
               if ((k >= 1) && (k <= 8)) begin
                  rx_b[k-1] = uart_txd;
               end else if (k == FRAME_BITS - 1) begin
                  check_val("rx_stop", 32'(uart_txd), 32'd1);
                  if (rx_b == 8'hEE) seen_ee = 1'b1;
                  if (exp_rx.size() == 0) check_val("rx_extra", 32'(rx_b), 32'h100);
                  else check_val("rx_byte", 32'(rx_b), 32'(exp_rx.pop_front()));
                  rx_on = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      int sent;
      int guard;
      logic [7:0] d;
      wr_if.tx_valid = 1'b0;
      wr_if.tx_data  = 8'h00;
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      check_val("rst_txd",   32'(uart_txd),       32'd1);
      check_val("rst_ready", 32'(wr_if.tx_ready), 32'd1);
      check_val("rst_busy",  32'(busy),           32'd0);
      check_val("rst_count", 32'(fifo_count),     32'd0);
      #600;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 100; i++) cycle(1'b0, 8'h00);

      // single byte
      cycle(1'b1, 8'hA5);
      drain();

      // back-to-back burst with tx_valid held
      sent  = 0;
      guard = 0;
      while ((sent < 16) && (guard < 2000)) begin
         cycle(1'b1, 8'(sent));
         if (m_acc) sent++;
         guard++;
      end
      check_val("b2b_sent", 32'(sent), 32'd16);
      drain();

      // fill FIFO, then offer 0xEE while full
      guard = 0;
      while ((m_q.size() < DEPTH) && (guard < 100)) begin
         cycle(1'b1, 8'($urandom_range(0, 237)));
         guard++;
      end
      check_val("full_count", 32'(fifo_count), 32'(DEPTH));
      cycle(1'b1, 8'hEE);
      cycle(1'b0, 8'h00);
      drain();
      check_val("ee_seen", 32'(seen_ee), 32'd0);

      // parity-relevant bytes
      cycle(1'b1, 8'h07);
      cycle(1'b1, 8'h03);
      drain();

      // random traffic
      for (int i = 0; i < 800; i++) begin
         d = 8'($urandom);
         cycle(1'($urandom_range(0, 3) == 0), d);
      end
      drain();

      // reset during data bit 3 of 0x55 with three bytes queued
      cycle(1'b1, 8'h55);
      cycle(1'b1, 8'h11);
      cycle(1'b1, 8'h22);
      cycle(1'b1, 8'h33);
      guard = 0;
      while (!(m_active && (m_pos == 4 * BAUD + 1)) && (guard < 200)) begin
         cycle(1'b0, 8'h00);
         guard++;
      end
      check_val("mid_queued", 32'(fifo_count), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      model_clear();
      check_val("mid_txd",   32'(uart_txd),       32'd1);
      check_val("mid_count", 32'(fifo_count),     32'd0);
      check_val("mid_ready", 32'(wr_if.tx_ready), 32'd1);
      check_val("mid_busy",  32'(busy),           32'd0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00);
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) cycle(1'b0, 8'h00);

      check_val("rx_pending", 32'(exp_rx.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Bus-side UART transmitter for the SoC serial link: accepts bytes through a valid/ready write port, buffers them in a small FIFO and serialises them onto uart_txd as 8N1 frames, LSB first.
- Counterpart to the existing UART receive path on uart_rxd.
- Sits between the CPU bridge's UART data register and the board pin.

Parameters:
- BAUD_DIV, 174, clk_in cycles per serial bit (20 MHz / 115200); legal range ≥ 2.
- FIFO_DEPTH, 8, byte entries in the TX FIFO; power of two, ≥ 2.

Ports:
- clk_in  input  1  system clock, rising edge.
- sys_rstn  input  1  asynchronous reset, active-low.
- tx_data  input  8  byte to enqueue.
- tx_valid  input  1  write request; sampled with tx_ready.
- tx_ready  output  1  FIFO not full; write accepted on an edge with tx_valid & tx_ready.
- uart_txd  output  1  serial output, idle high; registered.
- busy  output  1  FSM not in IDLE or FIFO non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently held in the FIFO.

Behaviour:
- Reset (async, sys_rstn=0), effective immediately:
  - uart_txd=1, tx_ready=1, busy=0, fifo_count=0.
  - FSM=IDLE; baud counter, bit index, FIFO pointers and shift register cleared.
  - Reset mid-frame aborts the frame; the line goes high at once and queued bytes are discarded.
- FSM states: IDLE, START, DATA, STOP (plus PARITY with the optional feature).
- IDLE:
  - uart_txd=1.
  - If FIFO non-empty at an edge: pop head into shift register, go to START.
- START: uart_txd=0 for BAUD_DIV cycles, then DATA with bit index 0.
- DATA:
  - uart_txd = shift[bit index] for BAUD_DIV cycles per bit, indices 0..7.
  - After bit 7 completes, go to STOP.
- STOP:
  - uart_txd=1 for BAUD_DIV cycles.
  - At completion, if FIFO non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Baud counter: counts 0..BAUD_DIV-1, reloads to 0 on every state or bit transition. No fractional divide.
- Latency:
  - Byte accepted at edge N into an empty FIFO with FSM in IDLE: popped at edge N+1; uart_txd low from edge N+1.
  - Frame length 10*BAUD_DIV cycles.
- FIFO:
  - Synchronous, first-word fall-through not required.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count updates on the edge after a push/pop; simultaneous push and pop leaves the count unchanged.
- Full: tx_ready=0 whenever fifo_count==FIFO_DEPTH. A tx_valid while full is ignored, even if a pop occurs in the same cycle (tx_ready is decided from the registered count).
- Empty: no pop is issued. tx_data is don't-care when tx_valid=0.
- busy falls on the edge at which STOP completes with the FIFO empty.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - Drives the even-parity bit (XOR of the 8 data bits) for BAUD_DIV cycles.
  - Frame becomes 8E1, 11*BAUD_DIV cycles.
- Undefined: no PARITY state and no parity logic; frame is 8N1.

Decomposition:
- Shared header uart_defs: FSM state encodings, default BAUD_DIV, 8-bit data width constant. Used by both RX and TX.
- One sub-module, uart_sync_fifo (parameterised by width and depth), exposing push, pop, full, empty and count. It is reusable for the RX side.
- FSM, baud counter and shift register stay in uart_tx_fifo.

Test Plan (BAUD_DIV=4, FIFO_DEPTH=8 unless noted):
- Reset:
  - Hold sys_rstn=0 600 ns, release.
  - Expect uart_txd=1, tx_ready=1, busy=0, fifo_count=0; no toggling for 100 cycles.
- Single byte 0xA5:
  - Write one cycle.
  - Expect uart_txd low from next edge for 4 cycles.
  - Then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles.
  - busy falls 40 cycles after the pop.
- Back-to-back:
  - Hold tx_valid with data 0x00..0x0F.
  - Expect tx_ready to drop once fifo_count=8.
  - Consecutive frames with stop bit followed immediately by the next start bit.
  - All 16 bytes decoded in order by a bench receiver.
- Full drop:
  - With FIFO full, pulse tx_valid with 0xEE.
  - Expect fifo_count unchanged and 0xEE never appearing on the line.
- Reset mid-frame:
  - Assert sys_rstn=0 during DATA bit 3 of 0x55 with 3 bytes queued.
  - Expect uart_txd=1 immediately, fifo_count=0, and no frames after release.
- Parity (UART_TX_PARITY_EN defined):
  - 0x07 gives parity bit 1; 0x03 gives parity bit 0.
  - Frame is 44 cycles.
